// File: rtl/vga_cfg_pkg.sv
// Shared types and defaults for the VGA timing-configuration write arbiter.
package vga_cfg_pkg;

  localparam int unsigned CONFIG_WIDTH        = 4;
  localparam int unsigned DEF_TIMEOUT_CYCLES  = 16;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_FRAME,
    ISSUE,
    WAIT_LOAD,
    RESP
  } state_e;

endpackage

// File: rtl/vga_cfg_arbiter_rr_priority_picker.sv
// Round-robin picker: first unmasked requester at or above ptr_i, wrapping to 0.
module rr_priority_picker #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned IW      = 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [NUM_REQ-1:0] mask_i,
  input  logic [IW-1:0]      ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [IW-1:0]      idx_o,
  output logic               any_o
);

  logic [NUM_REQ-1:0] eligible;

  assign eligible = req_i & ~mask_i;

  always_comb begin
    int unsigned k;
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    k       = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      k = 32'(ptr_i) + i;
      if (k >= NUM_REQ) k = k - NUM_REQ;
      if (!any_o && eligible[k[IW-1:0]]) begin
        any_o               = 1'b1;
        idx_o               = k[IW-1:0];
        grant_o[k[IW-1:0]]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/vga_cfg_arbiter.sv
// Round-robin arbiter for the VGA config write port; writes are released on Frame_end.
// Optional WAIT_LOAD timeout abort is enabled with VGA_CFG_TIMEOUT_EN.
module vga_cfg_arbiter
  import vga_cfg_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 2,
  parameter int unsigned CONFIG_WIDTH   = vga_cfg_pkg::CONFIG_WIDTH,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                            Clk,
  input  logic                            Rst,
  input  logic [NUM_REQ-1:0]              Req,
  input  logic [NUM_REQ*CONFIG_WIDTH-1:0] Req_addr,
  input  logic [NUM_REQ*CONFIG_WIDTH-1:0] Req_data,
  output logic [NUM_REQ-1:0]              Ack,
  input  logic                            Frame_end,
  input  logic                            Load_config,
  output logic                            Cfg_valid,
  output logic [CONFIG_WIDTH-1:0]         Cfg_addr,
  output logic [CONFIG_WIDTH-1:0]         Cfg_data,
  output logic                            Busy,
  output logic                            Err
);

  localparam int unsigned IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_e                  state_q, state_d;
  logic [IW-1:0]           ptr_q, ptr_d, gidx_q, gidx_d;
  logic [NUM_REQ-1:0]      gnt_q, gnt_d, mask_q, mask_d, ack_q, ack_d;
  logic [CONFIG_WIDTH-1:0] addr_q, addr_d, data_q, data_d;
  logic                    valid_q, valid_d, busy_q, busy_d, err_q, err_d;
  logic [NUM_REQ-1:0]      pick_grant;
  logic [IW-1:0]           pick_idx;
  logic                    pick_any;
  logic                    tmo_hit;

  rr_priority_picker #(
    .NUM_REQ (NUM_REQ),
    .IW      (IW)
  ) u_picker (
    .req_i   (Req),
    .mask_i  (mask_q),
    .ptr_i   (ptr_q),
    .grant_o (pick_grant),
    .idx_o   (pick_idx),
    .any_o   (pick_any)
  );

`ifdef VGA_CFG_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_q, tmo_d;

  // tmo_q counts completed WAIT_LOAD cycles; expiry on the last one
  assign tmo_hit = (tmo_q == TW'(TIMEOUT_CYCLES - 1));
  assign tmo_d   = (state_q == WAIT_LOAD) ? tmo_q + TW'(1) : '0;

  always_ff @(posedge Clk) begin
    if (Rst) tmo_q <= '0;
    else     tmo_q <= tmo_d;
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gidx_d  = gidx_q;
    gnt_d   = gnt_q;
    addr_d  = addr_q;
    data_d  = data_q;
    mask_d  = '0;
    ack_d   = '0;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pick_any) begin
          gidx_d  = pick_idx;
          gnt_d   = pick_grant;
          addr_d  = Req_addr[32'(pick_idx)*CONFIG_WIDTH +: CONFIG_WIDTH];
          data_d  = Req_data[32'(pick_idx)*CONFIG_WIDTH +: CONFIG_WIDTH];
          state_d = WAIT_FRAME;
        end
      end
      WAIT_FRAME: if (Frame_end) state_d = ISSUE;
      ISSUE:      state_d = WAIT_LOAD;
      WAIT_LOAD: begin
        // Ack/Err are registered, so they are set on the edge entering RESP
        if (Load_config) begin
          state_d = RESP;
          ack_d   = gnt_q;
        end else if (tmo_hit) begin
          state_d = RESP;
          ack_d   = gnt_q;
          err_d   = 1'b1;
        end
      end
      RESP: begin
        ptr_d   = (gidx_q == IW'(NUM_REQ - 1)) ? '0 : gidx_q + IW'(1);
        mask_d  = gnt_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    valid_d = (state_d == ISSUE);
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      gidx_q  <= '0;
      gnt_q   <= '0;
      mask_q  <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      ack_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gidx_q  <= gidx_d;
      gnt_q   <= gnt_d;
      mask_q  <= mask_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      ack_q   <= ack_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  assign Ack       = ack_q;
  assign Cfg_valid = valid_q;
  assign Cfg_addr  = addr_q;
  assign Cfg_data  = data_q;
  assign Busy      = busy_q;
  assign Err       = err_q;

endmodule

// File: tb/tb_vga_cfg_arbiter.sv
// Directed bench for vga_cfg_arbiter: vector table plus hand-written multi-cycle sequences.
module tb_vga_cfg_arbiter;

  logic       Clk = 1'b0;
  logic       Rst = 1'b1;
  logic [1:0] Req = '0;
  logic [7:0] Req_addr = '0;
  logic [7:0] Req_data = '0;
  logic [1:0] Ack;
  logic       Frame_end = 1'b0;
  logic       Load_config = 1'b0;
  logic       Cfg_valid;
  logic [3:0] Cfg_addr, Cfg_data;
  logic       Busy, Err;

  int checks = 0;
  int failures = 0;

  vga_cfg_arbiter #(
    .NUM_REQ        (2),
    .CONFIG_WIDTH   (4),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .Clk         (Clk),
    .Rst         (Rst),
    .Req         (Req),
    .Req_addr    (Req_addr),
    .Req_data    (Req_data),
    .Ack         (Ack),
    .Frame_end   (Frame_end),
    .Load_config (Load_config),
    .Cfg_valid   (Cfg_valid),
    .Cfg_addr    (Cfg_addr),
    .Cfg_data    (Cfg_data),
    .Busy        (Busy),
    .Err         (Err)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic       rst;
    logic [1:0] req;
    logic [7:0] addr;
    logic [7:0] data;
    logic       fe;
    logic       ld;
    logic       valid;
    logic [3:0] caddr;
    logic [3:0] cdata;
    logic [1:0] ack;
    logic       busy;
    logic       err;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic rst, input logic [1:0] req, input logic [7:0] addr,
                              input logic [7:0] data, input logic fe, input logic ld,
                              input logic valid, input logic [3:0] caddr, input logic [3:0] cdata,
                              input logic [1:0] ack, input logic busy, input logic err);
    vec_t v;
    v.rst = rst; v.req = req; v.addr = addr; v.data = data; v.fe = fe; v.ld = ld;
    v.valid = valid; v.caddr = caddr; v.cdata = cdata; v.ack = ack; v.busy = busy; v.err = err;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  function automatic logic [12:0] outs();
    return {Cfg_valid, Cfg_addr, Cfg_data, Ack, Busy, Err};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //          rst req  addr   data   fe ld | vld addr  data  ack  busy err
    // reset, then single request from 0 with Frame_end five cycles after grant
    vecs.push_back(mk(1, 2'b00, 8'hAB, 8'h20, 0, 0, 0, 4'h0, 4'h0, 2'b00, 0, 0));
    vecs.push_back(mk(1, 2'b01, 8'hAB, 8'h20, 0, 0, 0, 4'h0, 4'h0, 2'b00, 0, 0));
    vecs.push_back(mk(0, 2'b01, 8'hAB, 8'h20, 0, 0, 0, 4'hB, 4'h0, 2'b00, 1, 0));
    vecs.push_back(mk(0, 2'b00, 8'h55, 8'h55, 0, 0, 0, 4'hB, 4'h0, 2'b00, 1, 0));
    vecs.push_back(mk(0, 2'b00, 8'h55, 8'h55, 0, 0, 0, 4'hB, 4'h0, 2'b00, 1, 0));
    vecs.push_back(mk(0, 2'b00, 8'h55, 8'h55, 0, 0, 0, 4'hB, 4'h0, 2'b00, 1, 0));
    vecs.push_back(mk(0, 2'b00, 8'h55, 8'h55, 0, 0, 0, 4'hB, 4'h0, 2'b00, 1, 0));
    vecs.push_back(mk(0, 2'b00, 8'h55, 8'h55, 1, 0, 1, 4'hB, 4'h0, 2'b00, 1, 0));
    vecs.push_back(mk(0, 2'b00, 8'h55, 8'h55, 0, 0, 0, 4'hB, 4'h0, 2'b00, 1, 0));
    vecs.push_back(mk(0, 2'b00, 8'h55, 8'h55, 0, 0, 0, 4'hB, 4'h0, 2'b00, 1, 0));
    vecs.push_back(mk(0, 2'b00, 8'h55, 8'h55, 0, 1, 0, 4'hB, 4'h0, 2'b01, 1, 0));
    vecs.push_back(mk(0, 2'b00, 8'h55, 8'h55, 0, 0, 0, 4'hB, 4'h0, 2'b00, 0, 0));
    // Frame_end in the grant cycle is missed; Load_config in ISSUE ignored
    vecs.push_back(mk(0, 2'b10, 8'hAB, 8'h60, 1, 0, 0, 4'hA, 4'h6, 2'b00, 1, 0));
    vecs.push_back(mk(0, 2'b00, 8'hAB, 8'h60, 0, 0, 0, 4'hA, 4'h6, 2'b00, 1, 0));
    vecs.push_back(mk(0, 2'b00, 8'hAB, 8'h60, 1, 0, 1, 4'hA, 4'h6, 2'b00, 1, 0));
    vecs.push_back(mk(0, 2'b00, 8'hAB, 8'h60, 0, 1, 0, 4'hA, 4'h6, 2'b00, 1, 0));
    vecs.push_back(mk(0, 2'b00, 8'hAB, 8'h60, 0, 0, 0, 4'hA, 4'h6, 2'b00, 1, 0));
    vecs.push_back(mk(0, 2'b00, 8'hAB, 8'h60, 0, 1, 0, 4'hA, 4'h6, 2'b10, 1, 0));
    vecs.push_back(mk(0, 2'b00, 8'hAB, 8'h60, 0, 0, 0, 4'hA, 4'h6, 2'b00, 0, 0));
    // requester 0 holds Req through Ack: one masked IDLE cycle, then re-granted
    vecs.push_back(mk(0, 2'b01, 8'hAB, 8'h20, 0, 0, 0, 4'hB, 4'h0, 2'b00, 1, 0));
    vecs.push_back(mk(0, 2'b01, 8'hAB, 8'h20, 1, 0, 1, 4'hB, 4'h0, 2'b00, 1, 0));
    vecs.push_back(mk(0, 2'b01, 8'hAB, 8'h20, 0, 1, 0, 4'hB, 4'h0, 2'b00, 1, 0));
    vecs.push_back(mk(0, 2'b01, 8'hAB, 8'h20, 0, 1, 0, 4'hB, 4'h0, 2'b01, 1, 0));
    vecs.push_back(mk(0, 2'b01, 8'hAB, 8'h20, 0, 0, 0, 4'hB, 4'h0, 2'b00, 0, 0));
    vecs.push_back(mk(0, 2'b01, 8'hAB, 8'h20, 0, 0, 0, 4'hB, 4'h0, 2'b00, 0, 0));
    vecs.push_back(mk(0, 2'b01, 8'hAB, 8'h20, 0, 0, 0, 4'hB, 4'h0, 2'b00, 1, 0));
    vecs.push_back(mk(0, 2'b00, 8'hAB, 8'h20, 1, 0, 1, 4'hB, 4'h0, 2'b00, 1, 0));
    vecs.push_back(mk(0, 2'b00, 8'hAB, 8'h20, 0, 1, 0, 4'hB, 4'h0, 2'b00, 1, 0));
    vecs.push_back(mk(0, 2'b00, 8'hAB, 8'h20, 0, 1, 0, 4'hB, 4'h0, 2'b01, 1, 0));
    vecs.push_back(mk(0, 2'b00, 8'hAB, 8'h20, 0, 0, 0, 4'hB, 4'h0, 2'b00, 0, 0));
    // Req[1] drops one cycle after grant: 1010/0010 still issued and acked
    vecs.push_back(mk(0, 2'b10, 8'hAB, 8'h20, 0, 0, 0, 4'hA, 4'h2, 2'b00, 1, 0));
    vecs.push_back(mk(0, 2'b00, 8'hAB, 8'h20, 0, 0, 0, 4'hA, 4'h2, 2'b00, 1, 0));
    vecs.push_back(mk(0, 2'b00, 8'hAB, 8'h20, 1, 0, 1, 4'hA, 4'h2, 2'b00, 1, 0));
    vecs.push_back(mk(0, 2'b00, 8'hAB, 8'h20, 0, 0, 0, 4'hA, 4'h2, 2'b00, 1, 0));
    vecs.push_back(mk(0, 2'b00, 8'hAB, 8'h20, 0, 1, 0, 4'hA, 4'h2, 2'b10, 1, 0));
    vecs.push_back(mk(0, 2'b00, 8'hAB, 8'h20, 0, 0, 0, 4'hA, 4'h2, 2'b00, 0, 0));

    #2;
    foreach (vecs[i]) begin
      Rst         = vecs[i].rst;
      Req         = vecs[i].req;
      Req_addr    = vecs[i].addr;
      Req_data    = vecs[i].data;
      Frame_end   = vecs[i].fe;
      Load_config = vecs[i].ld;
      tick();
      check($sformatf("vec%0d", i), 32'(outs()),
            32'({vecs[i].valid, vecs[i].caddr, vecs[i].cdata, vecs[i].ack, vecs[i].busy, vecs[i].err}));
    end
    Req = '0; Frame_end = 0; Load_config = 0;

    // both requesters held: grants alternate 0,1,0,1
    Req_addr = 8'hAB;
    Req_data = 8'h96;
    Req = 2'b11;
    for (int k = 0; k < 4; k++) begin
      logic [1:0] exp_ack;
      logic [3:0] exp_addr;
      logic       seen;
      exp_ack  = (k % 2 == 0) ? 2'b01 : 2'b10;
      exp_addr = (k % 2 == 0) ? 4'hB : 4'hA;
      tick();
      check($sformatf("alt%0d_grant_addr", k), 32'({Busy, Cfg_addr}), 32'({1'b1, exp_addr}));
      Frame_end = 1;
      seen = 0;
      for (int c = 0; c < 4 && !seen; c++) begin
        tick();
        Frame_end = 0;
        seen = Cfg_valid;
      end
      check($sformatf("alt%0d_valid_seen", k), 32'(seen), 32'(1));
      tick();
      Load_config = 1;
      tick();
      Load_config = 0;
      check($sformatf("alt%0d_ack", k), 32'(Ack), 32'(exp_ack));
      tick();
    end
    Req = '0;
    tick();

    // reset while in WAIT_LOAD aborts without Ack
    Req = 2'b01; tick(); Req = 2'b00;
    Frame_end = 1; tick(); Frame_end = 0;
    tick();
    check("rst_pre_busy", 32'({Busy, Cfg_valid}), 32'(2'b10));
    Rst = 1; tick(); Rst = 0;
    check("rst_abort", 32'({Busy, Cfg_valid, Ack}), 32'(0));
    Load_config = 1; tick(); Load_config = 0;
    check("rst_late_load", 32'({Busy, Ack, Err}), 32'(0));
    tick();
    check("rst_late_load2", 32'({Busy, Ack, Err}), 32'(0));

    // stalled WAIT_LOAD: no Load_config
    Req = 2'b10; tick(); Req = 2'b00;
    Frame_end = 1; tick(); Frame_end = 0;
    check("tmo_issue", 32'(Cfg_valid), 32'(1));
`ifdef VGA_CFG_TIMEOUT_EN
    for (int c = 1; c <= 16; c++) begin
      tick();
      check($sformatf("tmo_wait%0d", c), 32'({Ack, Err, Busy}), 32'(4'b0001));
    end
    tick();
    check("tmo_expire", 32'({Ack, Err}), 32'(3'b101));
    tick();
    check("tmo_idle", 32'({Busy, Err}), 32'(0));
    // Load_config in the expiry cycle wins over the timeout
    Req = 2'b01; tick(); Req = 2'b00;
    Frame_end = 1; tick(); Frame_end = 0;
    for (int c = 1; c <= 16; c++) tick();
    Load_config = 1; tick(); Load_config = 0;
    check("tmo_race", 32'({Ack, Err}), 32'(3'b010));
    tick();
`else
    for (int c = 0; c < 40; c++) begin
      tick();
      check($sformatf("notmo_wait%0d", c), 32'({Busy, Ack, Err}), 32'(4'b1000));
    end
    Load_config = 1; tick(); Load_config = 0;
    check("notmo_ack", 32'({Ack, Err}), 32'(3'b100));
    tick();
    check("notmo_idle", 32'(Busy), 32'(0));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vga_cfg_arbiter.md
Name: vga_cfg_arbiter

Overview:
Shares the single VGA timing-configuration write port (Valid/Addr/Data into the config register block) between NUM_REQ requesters, e.g. the command decoder and the button mode-cycler. Round-robin grant; each write is held until the frame-end strobe so resolution changes never land mid-frame. Completion is confirmed by the config block's Load_config pulse, then returned to the requester as a one-cycle Ack.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
CONFIG_WIDTH, 4, width of Addr and Data, matches config block
TIMEOUT_CYCLES, 16, WAIT_LOAD cycles before abort (only with the optional feature)

Ports:
Clk  in  1  system clock
Rst  in  1  synchronous, active-high reset
Req  in  NUM_REQ  per-requester write request, level
Req_addr  in  NUM_REQ*CONFIG_WIDTH  packed addresses, requester i at [i*CONFIG_WIDTH +: CONFIG_WIDTH]
Req_data  in  NUM_REQ*CONFIG_WIDTH  packed data, same packing
Ack  out  NUM_REQ  one-hot, one-cycle completion pulse
Frame_end  in  1  one-cycle strobe at the start of vertical blanking
Load_config  in  1  pulse from the config block when a write is accepted
Cfg_valid  out  1  write strobe to the config block
Cfg_addr  out  CONFIG_WIDTH  write address
Cfg_data  out  CONFIG_WIDTH  write data
Busy  out  1  high in every state except IDLE
Err  out  1  one-cycle pulse, timeout abort

Behaviour:
- Reset (sync, Rst=1 at an edge): state IDLE. Cfg_valid, Cfg_addr, Cfg_data, Ack, Busy and Err all 0. rr_ptr=0. Reset mid-transaction aborts without an Ack; Cfg_valid is low from the next edge.
- All outputs are registered.
- IDLE: if any Req is high, grant the first set bit searching upward from rr_ptr with wrap. Latch the grant index g plus Req_addr[g] and Req_data[g] into Cfg_addr and Cfg_data, then go to WAIT_FRAME.
- WAIT_FRAME: Frame_end high -> ISSUE. Frame_end is sampled only in this state, so a strobe in the grant cycle is missed and the write waits for the next frame.
- ISSUE: Cfg_valid=1 for exactly one cycle -> WAIT_LOAD.
- WAIT_LOAD: Load_config high -> RESP. Load_config is ignored in every other state, including the ISSUE cycle.
- RESP: Ack[g]=1 for one cycle, rr_ptr=(g+1) mod NUM_REQ -> IDLE.
- In the first IDLE cycle after RESP, Req[g] is masked so a requester that has not yet dropped Req is not re-granted.
- Requester dropping Req after grant: the transaction still completes and Ack is still pulsed.
- Cfg_addr and Cfg_data are stable from grant through RESP. Later changes on Req_addr/Req_data are ignored.
- Simultaneous requests: exactly one grant per transaction. Starvation-free, and any requester waits at most NUM_REQ transactions.
- Config latency: grant to Cfg_valid is up to 1 frame + 2 cycles.

Optional Feature:
Macro VGA_CFG_TIMEOUT_EN.
- Defined: a counter runs in WAIT_LOAD. Once TIMEOUT_CYCLES cycles pass without Load_config (e.g. an unrecognised address), go to RESP and pulse Err together with Ack[g]. If Load_config arrives in the same cycle the count expires, it wins: no Err.
- Undefined: no counter, WAIT_LOAD waits indefinitely, Err is tied to 0.

Decomposition:
- Package vga_cfg_pkg holds:
  - CONFIG_WIDTH
  - the state enum (IDLE, WAIT_FRAME, ISSUE, WAIT_LOAD, RESP)
  - the default TIMEOUT_CYCLES
- One sub-module, rr_priority_picker: combinational. Inputs are the Req vector, the mask and rr_ptr; outputs are the one-hot grant, the grant index and any_req.

Test Plan:
- Req=01, addr/data 1011/00, Frame_end 5 cycles later -> Cfg_valid one cycle after Frame_end with 1011/00. Load_config 2 cycles later -> Ack=01 one cycle after that, Busy then low.
- Req=11 held continuously, 4 frames -> grants alternate 0,1,0,1 and Ack alternates 01,10,01,10.
- Frame_end coincides with the grant cycle -> no Cfg_valid until the next Frame_end.
- Req[1] drops 1 cycle after grant -> write 1010/10 is still issued and Ack=10 is still pulsed.
- Rst asserted in WAIT_LOAD -> next edge: Busy=0, Cfg_valid=0, Ack=0. A later Load_config causes no Ack.
- VGA_CFG_TIMEOUT_EN defined, no Load_config -> Ack and Err pulse together exactly 16 WAIT_LOAD cycles after ISSUE. Undefined -> Busy stays high indefinitely.
